exec_stim_gen: RTL and testbench

- Parametrised, synthesizable EXEC-side stimulus engine for IFD unit-level validation.
- Drives stall and PC_value into the instruction decoder in two phases:
  - Phase 1: a burst of N1 stall-toggle/PC-increment steps.
  - Jump back to a programmable address.
  - Phase 2: a second burst of N2 steps.
- Step delays come from a seedable LFSR or a fixed value, so stimulus is repeatable across simulators and usable on FPGA.
- Adds hold/pause and restart, and reports busy/done/step count for scoreboards.

---
 rtl/exec_stim_gen_if.sv | 30 +++
 rtl/exec_stim_gen.sv | 178 +++++++++++++++++
 tb/tb_exec_stim_gen.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stim_gen_if.sv
// Handshake/stimulus bundle between the EXEC-side stimulus engine and its driver.
// The master side drives the controls; the slave side (the engine) drives stall/PC and status.
interface exec_stim_gen_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DELAY_WIDTH = 4,
  parameter int LFSR_WIDTH  = 16
);
  logic                   start;
  logic                   hold;
  logic                   load_seed;
  logic [LFSR_WIDTH-1:0]  seed;
  logic                   fixed_delay_en;
  logic [DELAY_WIDTH-1:0] fixed_delay;
  logic [ADDR_WIDTH-1:0]  jump_pc;
  logic                   stall;
  logic [ADDR_WIDTH-1:0]  PC_value;
  logic                   busy;
  logic                   done;
  logic [7:0]             step_count;

  modport master (
    output start, hold, load_seed, seed, fixed_delay_en, fixed_delay, jump_pc,
    input  stall, PC_value, busy, done, step_count
  );

  modport slave (
    input  start, hold, load_seed, seed, fixed_delay_en, fixed_delay, jump_pc,
    output stall, PC_value, busy, done, step_count
  );
endinterface

// File: rtl/exec_stim_gen.sv
// Two-phase stall/PC stimulus engine for instruction-decoder validation.
// Each step toggles stall, waits D, bumps PC, waits D; D comes from an LFSR or a fixed value.
module exec_stim_gen #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DELAY_WIDTH = 4,
  parameter int                    MIN_DELAY   = 2,
  parameter int                    N1          = 10,
  parameter int                    N2          = 5,
  parameter logic [ADDR_WIDTH-1:0] START_PC    = 12'o200,
  parameter int                    LFSR_WIDTH  = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  exec_stim_gen_if.slave   bus
);

  localparam int CNT_W = $clog2(MIN_DELAY + (1 << DELAY_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_WAIT_A, S_WAIT_B, S_JUMP, S_JUMP_WAIT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        dly_q, dly_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    stall_q, stall_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              step_q, step_d;
  logic                    phase_q, phase_d;
  logic                    sample_en;
  logic [CNT_W-1:0]        dly_sample;
  logic [7:0]              n_cur;

  // All-ones raw value folds to zero so the delay range stays 2^W-1 wide.
  function automatic logic [CNT_W-1:0] delay_of(input logic [DELAY_WIDTH-1:0] raw);
    logic [DELAY_WIDTH-1:0] r;
    r = (&raw) ? '0 : raw;
    return CNT_W'(MIN_DELAY) + CNT_W'(r);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  assign dly_sample = delay_of(bus.fixed_delay_en ? bus.fixed_delay
                                                  : lfsr_q[DELAY_WIDTH-1:0]);
  assign n_cur      = phase_q ? 8'(N2) : 8'(N1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    lfsr_d    = lfsr_q;
    stall_d   = stall_q;
    pc_d      = pc_q;
    busy_d    = busy_q;
    done_d    = done_q;
    step_d    = step_q;
    phase_d   = phase_q;
    sample_en = 1'b0;
    if (!bus.hold) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_d  = 1'b1;
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          stall_d   = ~stall_q;
          sample_en = 1'b1;
          dly_d     = dly_sample;
          cnt_d     = dly_sample - CNT_W'(1);
          step_d    = sat_inc(step_q);
          state_d   = S_WAIT_A;
        end
        S_WAIT_A: begin
          if (cnt_q == '0) begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            cnt_d   = dly_q - CNT_W'(1);
            state_d = S_WAIT_B;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_B: begin
          if (cnt_q == '0) begin
            if (step_q < n_cur) begin
              state_d = S_STEP;
            end else if (!phase_q) begin
              state_d = S_JUMP;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_JUMP: begin
          // The jump gap reuses the last sampled delay rather than drawing a new one.
          stall_d = 1'b0;
          pc_d    = bus.jump_pc;
          cnt_d   = dly_q - CNT_W'(1);
          state_d = S_JUMP_WAIT;
        end
        S_JUMP_WAIT: begin
          if (cnt_q == '0) begin
            stall_d = 1'b1;
            step_d  = 8'd0;
            phase_d = 1'b1;
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.start) begin
            pc_d    = START_PC;
            stall_d = 1'b1;
            done_d  = 1'b0;
            step_d  = 8'd0;
            phase_d = 1'b0;
            busy_d  = 1'b1;
            state_d = S_STEP;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (sample_en) lfsr_d = lfsr_next(lfsr_q);
      // A zero seed would lock the LFSR, so it is ignored.
      if (bus.load_seed && (bus.seed != '0)) lfsr_d = bus.seed;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dly_q   <= CNT_W'(MIN_DELAY);
      lfsr_q  <= LFSR_SEED;
      stall_q <= 1'b1;
      pc_q    <= START_PC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  assign bus.stall      = stall_q;
  assign bus.PC_value   = pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_count = step_q;

endmodule

// File: tb/tb_exec_stim_gen.sv
// Scoreboard bench for exec_stim_gen: a sequence-level model predicts every output change per run.
// A negedge monitor pops predictions whenever stall/PC/busy/done change and compares them.
module tb_exec_stim_gen;
  localparam logic [11:0] START = 12'o200;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exec_stim_gen_if bus ();
  exec_stim_gen_if bw ();

  exec_stim_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  exec_stim_gen #(.START_PC(12'o7776), .N1(3)) dut_w (.clk(clk), .reset_n(reset_n), .bus(bw));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; logic s; logic [11:0] pc; logic b; logic d; logic [7:0] sc;} ev_t;
  typedef struct {int t; logic s; logic [11:0] pc;} tr_t;
  ev_t  sbq[$];
  tr_t  qa[$], qb[$];
  logic [11:0] wq[$];

  // Reference model state
  logic        m_stall, m_busy, m_done, m_fen;
  logic [11:0] m_pc, m_jump;
  logic [7:0]  m_sc;
  logic [15:0] m_lfsr;
  logic [3:0]  m_fix;
  int          m_tend, t_start;
  logic        le_stall, le_busy, le_done;
  logic [11:0] le_pc;
  int          rec_sel = 0;
  bit          gap_en = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string n, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", n, v, lo, hi);
    end
  endtask

  function automatic int pk(logic s, logic [11:0] pc, logic b, logic d, logic [7:0] sc);
    return int'({s, pc, b, d, sc});
  endfunction

  task automatic model_reset();
    m_stall = 1'b1; m_pc = START; m_busy = 1'b0; m_done = 1'b0; m_sc = 8'd0;
    m_lfsr = 16'hACE1;
    le_stall = 1'b1; le_pc = START; le_busy = 1'b0; le_done = 1'b0;
  endtask

  task automatic emit(input int t);
    ev_t e;
    e.t = t; e.s = m_stall; e.pc = m_pc; e.b = m_busy; e.d = m_done; e.sc = m_sc;
    if (e.s != le_stall || e.pc != le_pc || e.b != le_busy || e.d != le_done)
      sbq.push_back(e);
    le_stall = e.s; le_pc = e.pc; le_busy = e.b; le_done = e.d;
  endtask

  task automatic sample(output int d);
    int r;
    r = m_fen ? int'(m_fix) : int'(m_lfsr & 16'h000F);
    if (r == 15) r = 0;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    d = 2 + r;
  endtask

  // Whole-run prediction: phase 1 (10 steps), jump gap, phase 2 (5 steps), done.
  task automatic push_run(input int t0);
    int t, d, n;
    t = t0; d = 2;
    m_busy = 1'b1; m_pc = START; m_stall = 1'b1; m_done = 1'b0; m_sc = 8'd0;
    emit(t);
    for (int p = 0; p < 2; p++) begin
      n = (p == 0) ? 10 : 5;
      for (int k = 1; k <= n; k++) begin
        t++; m_stall = ~m_stall; sample(d); m_sc = (k > 255) ? 8'd255 : 8'(k); emit(t);
        t += d; m_pc = m_pc + 12'd1; emit(t);
        t += d;
      end
      if (p == 0) begin
        t++; m_stall = 1'b0; m_pc = m_jump; emit(t);
        t += d; m_stall = 1'b1; m_sc = 8'd0; emit(t);
      end else begin
        m_done = 1'b1; m_busy = 1'b0; emit(t);
      end
    end
    m_tend = t;
  endtask

  task automatic do_run(input bit fen, input logic [3:0] fix, input int rec);
    @(negedge clk);
    bus.fixed_delay_en = fen; bus.fixed_delay = fix;
    m_fen = fen; m_fix = fix; m_jump = bus.jump_pc;
    rec_sel = rec;
    bus.start = 1'b1;
    t_start = cyc + 1;
    push_run(t_start);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_run(output int t);
    int n;
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge clk); n++; end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    t = cyc;
    chk("done_time", t, m_tend);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    sbq.delete();
    rec_sel = 0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every visible output change must match the next prediction.
  initial begin
    logic        p_stall, p_busy, p_done;
    logic [11:0] p_pc;
    int          last_t;
    ev_t         e;
    tr_t         r;
    last_t = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_stall = bus.stall; p_pc = bus.PC_value; p_busy = bus.busy; p_done = bus.done;
      end else if (bus.stall !== p_stall || bus.PC_value !== p_pc ||
                   bus.busy !== p_busy || bus.done !== p_done) begin
        if (gap_en && bus.busy && bus.stall == p_stall && bus.PC_value == p_pc + 12'd1)
          chk_rng("step_gap", cyc - last_t, 2, 16);
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change actual=%0d required=none (cycle %0d)",
                   pk(bus.stall, bus.PC_value, bus.busy, bus.done, bus.step_count), cyc);
        end else begin
          e = sbq.pop_front();
          chk("evt_time", cyc, e.t);
          chk("evt_outputs", pk(bus.stall, bus.PC_value, bus.busy, bus.done, bus.step_count),
              pk(e.s, e.pc, e.b, e.d, e.sc));
        end
        r.t = cyc - t_start; r.s = bus.stall; r.pc = bus.PC_value;
        if (rec_sel == 1) qa.push_back(r);
        else if (rec_sel == 2) qb.push_back(r);
        last_t = cyc;
        p_stall = bus.stall; p_pc = bus.PC_value; p_busy = bus.busy; p_done = bus.done;
      end
    end
  end

  // PC trace of the wrap-around instance.
  initial begin
    logic [11:0] wprev;
    wprev = 12'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) wprev = bw.PC_value;
      else if (bw.PC_value != wprev) begin
        wq.push_back(bw.PC_value);
        wprev = bw.PC_value;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, h0, t_ref;
    reset_n = 1'b0;
    bus.start = 0; bus.hold = 0; bus.load_seed = 0; bus.seed = 16'h0;
    bus.fixed_delay_en = 1; bus.fixed_delay = 4'd0; bus.jump_pc = 12'o200;
    bw.start = 0; bw.hold = 0; bw.load_seed = 0; bw.seed = 16'h0;
    bw.fixed_delay_en = 1; bw.fixed_delay = 4'd0; bw.jump_pc = 12'o100;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_stall", int'(bus.stall), 1);
    chk("rst_pc", int'(bus.PC_value), int'(START));
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_step_count", int'(bus.step_count), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Wrap-around instance runs alongside the first fixed-delay run.
    bw.start = 1'b1;
    @(negedge clk);
    bw.start = 1'b0;

    // Run 1: fixed delay 0 -> D=2
    do_run(1'b1, 4'd0, 0);
    wait_cyc(t_start + 3);
    chk("pc_after_3", int'(bus.PC_value), 12'o201);
    wait_cyc(t_start + 50);
    chk("pc_after_50", int'(bus.PC_value), 12'o212);
    wait_cyc(t_start + 52);
    chk("jump_wait_pc", int'(bus.PC_value), 12'o200);
    chk("jump_wait_stall", int'(bus.stall), 0);
    finish_run(t);
    chk("done_edge", t - t_start, 78);
    chk("final_pc", int'(bus.PC_value), 12'o205);
    chk("final_stall", int'(bus.stall), 0);
    chk("final_busy", int'(bus.busy), 0);

    chk("wrap_len_ok", int'(wq.size() >= 4), 1);
    if (wq.size() >= 4) begin
      chk("wrap_pc0", int'(wq[0]), 12'o7777);
      chk("wrap_pc1", int'(wq[1]), 12'o0000);
      chk("wrap_pc2", int'(wq[2]), 12'o0001);
      chk("wrap_jump", int'(wq[3]), 12'o100);
    end

    // Run 2: all-ones fixed delay folds to D=2
    do_run(1'b1, 4'hF, 0);
    finish_run(t);
    chk("allones_done_edge", t - t_start, 78);

    // Run 3: LFSR from reset seed, with start and zero-seed load applied mid-run
    gap_en = 1;
    do_run(1'b0, 4'd0, 0);
    wait_cyc(t_start + 20);
    bus.start = 1'b1; bus.load_seed = 1'b1; bus.seed = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0; bus.load_seed = 1'b0;
    finish_run(t);

    // Runs 4/5: same seed twice must give identical traces
    for (int run = 1; run <= 2; run++) begin
      @(negedge clk);
      bus.load_seed = 1'b1; bus.seed = 16'h1234; m_lfsr = 16'h1234;
      @(negedge clk);
      bus.load_seed = 1'b0; bus.seed = 16'h0;
      do_run(1'b0, 4'd0, run);
      finish_run(t);
    end
    gap_en = 0;
    chk("trace_len", qb.size(), qa.size());
    for (int i = 0; i < qa.size() && i < qb.size(); i++) begin
      chk("trace_time", qb[i].t, qa[i].t);
      chk("trace_val", int'({qb[i].s, qb[i].pc}), int'({qa[i].s, qa[i].pc}));
    end

    // Run 6: hold for 7 cycles in WAIT_A of step 1 (D=5)
    do_run(1'b1, 4'd3, 0);
    t_ref = m_tend;
    wait_cyc(t_start + 2);
    h0 = t_start + 3;
    foreach (sbq[i]) if (sbq[i].t >= h0) sbq[i].t += 7;
    m_tend += 7;
    bus.hold = 1'b1; bus.start = 1'b1;
    repeat (7) begin
      @(negedge clk);
      chk("hold_step_count", int'(bus.step_count), 1);
      chk("hold_pc", int'(bus.PC_value), 12'o200);
      chk("hold_stall", int'(bus.stall), 0);
    end
    bus.hold = 1'b0; bus.start = 1'b0;
    finish_run(t);
    chk("hold_delay", t - t_ref, 7);

    // Run 7: async reset in phase 2, then a full rerun
    do_run(1'b1, 4'd0, 0);
    wait_cyc(t_start + 60);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_stall", int'(bus.stall), 1);
    chk("arst_pc", int'(bus.PC_value), 12'o200);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_step_count", int'(bus.step_count), 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    do_run(1'b1, 4'd0, 0);
    finish_run(t);
    chk("rerun_done_edge", t - t_start, 78);
    chk("rerun_final_pc", int'(bus.PC_value), 12'o205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
